// File: rtl/yc_niu_target.sv
// yc_niu_target: responder NIU that executes single-flit requests against a local register store.
// Define YC_NIU_TGT_DSTCHK_EN to drop misrouted requests and expose misroute_cnt.
package yc_niu_pkg;
    typedef struct packed {
        logic [3:0]  dst_x;
        logic [3:0]  dst_y;
        logic [3:0]  src_x;
        logic [3:0]  src_y;
        logic [31:0] payload;
    } flit_t;
    localparam logic [1:0] OP_PING = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_ERR = 2'b11;
endpackage

module yc_niu_target
    import yc_niu_pkg::*;
#(
    parameter int MY_X      = 1,
    parameter int MY_Y      = 0,
    parameter int MEM_DEPTH = 16,
    parameter int RX_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  flit_t       rx_flit,
    output logic        rx_ready,
    output logic        tx_valid,
    output flit_t       tx_flit,
    input  logic        tx_ready,
`ifdef YC_NIU_TGT_DSTCHK_EN
    output logic [15:0] misroute_cnt,
`endif
    output logic [15:0] req_cnt,
    output logic [15:0] rsp_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2;
    localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int FAW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [FAW-1:0] F_LAST = FAW'(RX_DEPTH - 1);
    localparam logic [FAW:0] F_FULL = (FAW + 1)'(RX_DEPTH);
    localparam logic [8:0] M_LIM = 9'(MEM_DEPTH);

    logic [1:0]     r_state;
    logic           r_up;
    flit_t          r_fifo [RX_DEPTH];
    logic [FAW-1:0] r_wp, r_rp;
    logic [FAW:0]   r_cnt;
    flit_t          r_req, r_tx;
    logic [15:0]    r_mem [MEM_DEPTH];
    logic [15:0]    r_req_cnt, r_rsp_cnt;
    logic           w_empty, w_full, w_push, w_pop, w_exec, w_drop, w_bad, w_done;
    logic [1:0]     w_op;
    logic [7:0]     w_addr;
    flit_t          w_rsp;

    assign w_empty  = r_cnt == '0;
    assign w_full   = r_cnt == F_FULL;
    // rx_ready stays low until the first clock after reset release
    assign rx_ready = r_up && !w_full;
    assign w_push   = rx_valid && rx_ready;
    assign w_exec   = r_state == S_EXEC;
    assign w_done   = (r_state == S_RESP) && tx_ready;
    assign w_op     = r_req.payload[31:30];
    assign w_addr   = r_req.payload[23:16];
    assign w_bad    = (w_op == OP_ERR) || ({1'b0, w_addr} >= M_LIM);
`ifdef YC_NIU_TGT_DSTCHK_EN
    assign w_drop   = w_exec && ((r_req.dst_x != 4'(MY_X)) || (r_req.dst_y != 4'(MY_Y)));
`else
    assign w_drop   = 1'b0;
`endif
    assign w_pop    = !w_empty && ((r_state == S_IDLE) || w_drop || w_done);
    assign tx_valid = r_state == S_RESP;
    assign tx_flit  = r_tx;
    assign req_cnt  = r_req_cnt;
    assign rsp_cnt  = r_rsp_cnt;

    always_comb begin
        w_rsp               = '0;
        w_rsp.dst_x         = r_req.src_x;
        w_rsp.dst_y         = r_req.src_y;
        w_rsp.src_x         = 4'(MY_X);
        w_rsp.src_y         = 4'(MY_Y);
        w_rsp.payload[29:16] = r_req.payload[29:16];
        w_rsp.payload[31:30] = w_bad ? OP_ERR : w_op;
        w_rsp.payload[15:0]  = w_bad ? 16'hDEAD :
                               (w_op == OP_READ) ? r_mem[w_addr[MAW-1:0]] : r_req.payload[15:0];
    end

    always_ff @(posedge clk)
        if (w_push) r_fifo[r_wp] <= rx_flit;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == F_LAST) ? '0 : r_wp + 1'b1;
            if (w_pop) r_rp <= (r_rp == F_LAST) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + (FAW + 1)'(w_push) - (FAW + 1)'(w_pop);
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_exec && !w_drop && !w_bad && (w_op == OP_WRITE)) begin
            r_mem[w_addr[MAW-1:0]] <= r_req.payload[15:0];
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state   <= S_IDLE;
            r_up      <= 1'b0;
            r_req     <= '0;
            r_tx      <= '0;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
        end else begin
            r_up <= 1'b1;
            if (w_pop) r_req <= r_fifo[r_rp];
            if (w_exec && !w_drop) r_tx <= w_rsp;
            if (w_push) r_req_cnt <= r_req_cnt + 16'd1;
            if (w_done) r_rsp_cnt <= r_rsp_cnt + 16'd1;
            r_state <= w_pop ? S_EXEC :
                       (w_exec && !w_drop) ? S_RESP :
                       ((r_state == S_RESP) && !tx_ready) ? S_RESP : S_IDLE;
        end

`ifdef YC_NIU_TGT_DSTCHK_EN
    logic [15:0] r_mis_cnt;
    assign misroute_cnt = r_mis_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_mis_cnt <= '0;
        else if (w_drop) r_mis_cnt <= r_mis_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_yc_niu_target.sv
// tb_yc_niu_target: scoreboard bench for yc_niu_target with directed request vectors.
module tb_yc_niu_target;
    import yc_niu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    flit_t       rx_flit = '0;
    logic        rx_ready;
    logic        tx_valid;
    flit_t       tx_flit;
    logic        tx_ready = 1'b1;
    logic [15:0] req_cnt, rsp_cnt;
`ifdef YC_NIU_TGT_DSTCHK_EN
    logic [15:0] misroute_cnt;
`endif

    int checks = 0;
    int failures = 0;
    flit_t exp_q[$];

    yc_niu_target #(.MY_X(1), .MY_Y(0), .MEM_DEPTH(16), .RX_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_flit(rx_flit), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_flit(tx_flit), .tx_ready(tx_ready),
`ifdef YC_NIU_TGT_DSTCHK_EN
        .misroute_cnt(misroute_cnt),
`endif
        .req_cnt(req_cnt), .rsp_cnt(rsp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input logic [1:0] op, input logic [5:0] tag, input logic [7:0] addr,
                                 input logic [15:0] data, input logic [3:0] sx, input logic [3:0] sy,
                                 input logic [3:0] dx, input logic [3:0] dy);
        flit_t f;
        f = '0;
        f.src_x = sx;
        f.src_y = sy;
        f.dst_x = dx;
        f.dst_y = dy;
        f.payload = {op, tag, addr, data};
        return f;
    endfunction

    // returns #1 after the accepting clock edge
    task automatic send_flit(input flit_t f);
        bit ok;
        ok = 0;
        rx_valid = 1'b1;
        rx_flit = f;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
        end
        #1;
        rx_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic req(input logic [1:0] op, input logic [5:0] tag, input logic [7:0] addr,
                       input logic [15:0] data, input logic [1:0] eop, input logic [15:0] edata);
        exp_q.push_back(mk(eop, tag, addr, edata, 4'd1, 4'd0, 4'd0, 4'd0));
        send_flit(mk(op, tag, addr, data, 4'd0, 4'd0, 4'd1, 4'd0));
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0) && !tx_valid;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // monitor: compares every delivered response and checks hold stability under backpressure
    initial begin
        logic  held;
        flit_t hflit;
        flit_t e;
        held = 0;
        hflit = '0;
        forever begin
            @(negedge clk);
            if (rst) held = 0;
            else begin
                if (held) chk("tx_hold_stable", {15'd0, tx_valid, tx_flit}, {15'd0, 1'b1, hflit});
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_rsp", 64'(tx_flit), 64'd0 - 64'd1);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_flit", 64'(tx_flit), 64'(e));
                    end
                end
                held = tx_valid && !tx_ready;
                hflit = tx_flit;
            end
        end
    end

    initial begin
        #2;
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_flit", 64'(tx_flit), 64'd0);
        chk("rst_counters", {32'd0, req_cnt, rsp_cnt}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("rx_ready_after_rst", 64'(rx_ready), 64'd1);

        req(OP_WRITE, 6'd5, 8'd3, 16'hBEEF, OP_WRITE, 16'hBEEF);
        @(posedge clk);
        #1 chk("lat_t1_tx_valid", 64'(tx_valid), 64'd0);
        @(posedge clk);
        #1 chk("lat_t2_tx_valid", 64'(tx_valid), 64'd1);
        chk("req_cnt_1", 64'(req_cnt), 64'd1);
        chk("rsp_cnt_0", 64'(rsp_cnt), 64'd0);
        @(posedge clk);
        #1 chk("rsp_cnt_1", 64'(rsp_cnt), 64'd1);

        req(OP_READ,  6'd6,  8'd3,  16'h0000, OP_READ,  16'hBEEF);
        req(OP_READ,  6'd7,  8'd4,  16'h0000, OP_READ,  16'h0000);
        req(OP_READ,  6'd8,  8'd20, 16'h0000, OP_ERR,   16'hDEAD);
        req(OP_READ,  6'd9,  8'd4,  16'h0000, OP_READ,  16'h0000);
        req(OP_PING,  6'd10, 8'd0,  16'h1234, OP_PING,  16'h1234);
        req(OP_ERR,   6'd11, 8'd2,  16'h7777, OP_ERR,   16'hDEAD);
        req(OP_WRITE, 6'd12, 8'd15, 16'hA5A5, OP_WRITE, 16'hA5A5);
        req(OP_READ,  6'd13, 8'd15, 16'h0000, OP_READ,  16'hA5A5);
        req(OP_WRITE, 6'd14, 8'd16, 16'h4321, OP_ERR,   16'hDEAD);
        req(OP_WRITE, 6'd15, 8'd7,  16'h1111, OP_WRITE, 16'h1111);
        req(OP_READ,  6'd16, 8'd7,  16'h0000, OP_READ,  16'h1111);
        drain();
        chk("cnt_after_batch", {32'd0, req_cnt, rsp_cnt}, {32'd0, 16'd12, 16'd12});

        tx_ready = 1'b0;
        req(OP_PING, 6'd1, 8'd0, 16'h0001, OP_PING, 16'h0001);
        req(OP_PING, 6'd2, 8'd0, 16'h0002, OP_PING, 16'h0002);
        req(OP_PING, 6'd3, 8'd0, 16'h0003, OP_PING, 16'h0003);
        chk("rx_ready_full", 64'(rx_ready), 64'd0);
        repeat (10) @(posedge clk);
        #1 chk("rx_ready_still_full", 64'(rx_ready), 64'd0);
        chk("stall_tx_valid", 64'(tx_valid), 64'd1);
        tx_ready = 1'b1;
        drain();
        chk("rsp_cnt_after_stall", 64'(rsp_cnt), 64'd15);

        tx_ready = 1'b0;
        req(OP_PING, 6'd40, 8'd0, 16'h0040, OP_PING, 16'h0040);
        req(OP_PING, 6'd41, 8'd0, 16'h0041, OP_PING, 16'h0041);
        req(OP_PING, 6'd42, 8'd0, 16'h0042, OP_PING, 16'h0042);
        chk("pre_rst_tx_valid", 64'(tx_valid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1 chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 chk("mid_rst_counters", {32'd0, req_cnt, rsp_cnt}, 64'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        req(OP_PING, 6'd20, 8'd1, 16'h5A5A, OP_PING, 16'h5A5A);
        @(posedge clk);
        #1 chk("post_rst_lat_t1", 64'(tx_valid), 64'd0);
        @(posedge clk);
        #1 chk("post_rst_lat_t2", 64'(tx_valid), 64'd1);
        req(OP_READ, 6'd21, 8'd3, 16'h0000, OP_READ, 16'h0000);
        drain();
        chk("cnt_after_rst", {32'd0, req_cnt, rsp_cnt}, {32'd0, 16'd2, 16'd2});

`ifdef YC_NIU_TGT_DSTCHK_EN
        begin
            bit seen;
            seen = 0;
            send_flit(mk(OP_WRITE, 6'd30, 8'd3, 16'h9999, 4'd0, 4'd0, 4'd2, 4'd0));
            for (int n = 0; n < 10; n++) begin
                @(posedge clk);
                #1 if (tx_valid) seen = 1;
            end
            chk("misroute_no_rsp", 64'(seen), 64'd0);
            chk("misroute_cnt", 64'(misroute_cnt), 64'd1);
            req(OP_READ, 6'd31, 8'd3, 16'h0000, OP_READ, 16'h0000);
            drain();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
